// File: rtl/cr_fifo_rd_drain.sv
// Show-ahead FIFO read consumer: 2-entry skid buffer onto a registered valid/ready
// stream, software drain that discards FIFO contents, saturating stats, sticky ECC flag.
module cr_fifo_rd_drain #(
  parameter int DATA_W = 106,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              fifo_ecc_err,
  output logic              fifo_ren,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              drain_req,
  output logic              drain_busy,
  output logic              drain_done,
  input  logic              err_clr,
  output logic              ecc_err_sticky,
  output logic [CNT_W-1:0]  pop_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic              done_q, done_d;
  logic              ecc_q, ecc_d;
  logic [CNT_W-1:0]  pop_cnt_q, pop_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic              ren;
  logic              push;
  logic              pop;
  logic [1:0]        drop_inc;
  logic [CNT_W:0]    drop_sum;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    head_d    = head_q;
    tail_d    = tail_q;
    done_d    = 1'b0;
    pop_cnt_d = pop_cnt_q;
    drop_inc  = 2'd0;
    ren       = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;

    case (state_q)
      ST_RUN: begin
        ren  = !fifo_empty && (cnt_q != 2'd2);
        push = ren;
        pop  = (cnt_q != 2'd0) && out_ready;
        case (cnt_q)
          2'd0: begin
            if (push) head_d = fifo_rdata;
          end
          2'd1: begin
            if (push && pop)  head_d = fifo_rdata;
            if (push && !pop) tail_d = fifo_rdata;
          end
          default: begin
            if (pop) head_d = tail_q;
          end
        endcase
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        if (pop && (pop_cnt_q != CNT_MAX)) pop_cnt_d = pop_cnt_q + 1'b1;
        // Whatever would still be buffered after this cycle, including an entry
        // popped from the FIFO in the request cycle, is counted as dropped.
        if (drain_req) begin
          state_d  = ST_DRAIN;
          drop_inc = cnt_d;
          cnt_d    = 2'd0;
        end
      end
      ST_DRAIN: begin
        ren      = !fifo_empty;
        drop_inc = {1'b0, ren};
        if (fifo_empty) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(drop_inc);
    drop_cnt_d = drop_sum[CNT_W] ? CNT_MAX : drop_sum[CNT_W-1:0];

    if (ren && fifo_ecc_err) ecc_d = 1'b1;
    else if (err_clr)        ecc_d = 1'b0;
    else                     ecc_d = ecc_q;

    fifo_ren = ren && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      done_q     <= 1'b0;
      ecc_q      <= 1'b0;
      pop_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      done_q     <= done_d;
      ecc_q      <= ecc_d;
      pop_cnt_q  <= pop_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_valid      = (cnt_q != 2'd0);
  assign out_data       = head_q;
  assign drain_busy     = (state_q == ST_DRAIN);
  assign drain_done     = done_q;
  assign ecc_err_sticky = ecc_q;
  assign pop_cnt        = pop_cnt_q;
  assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_cr_fifo_rd_drain.sv
// Bench for cr_fifo_rd_drain: queue-based FIFO and stream model, per-cycle scoreboard,
// scenario tasks with targeted checks, plus a CNT_W=4 instance for counter saturation.
module tb_cr_fifo_rd_drain;
  localparam int DW = 106;

  typedef struct packed {
    logic          ecc;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_ecc_err = 1'b0;
  logic          out_ready = 1'b0;
  logic          drain_req = 1'b0;
  logic          err_clr = 1'b0;

  logic          fifo_ren, out_valid, drain_busy, drain_done, ecc_err_sticky;
  logic [DW-1:0] out_data;
  logic [15:0]   pop_cnt, drop_cnt;

  logic          s_fifo_ren, s_out_valid, s_drain_busy, s_drain_done, s_ecc;
  logic [DW-1:0] s_out_data;
  logic [3:0]    s_pop_cnt, s_drop_cnt;

  cr_fifo_rd_drain #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_ecc_err(fifo_ecc_err), .fifo_ren(fifo_ren), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .drain_req(drain_req),
    .drain_busy(drain_busy), .drain_done(drain_done), .err_clr(err_clr),
    .ecc_err_sticky(ecc_err_sticky), .pop_cnt(pop_cnt), .drop_cnt(drop_cnt)
  );

  cr_fifo_rd_drain #(.DATA_W(DW), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_ecc_err(fifo_ecc_err), .fifo_ren(s_fifo_ren), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_data(s_out_data), .drain_req(drain_req),
    .drain_busy(s_drain_busy), .drain_done(s_drain_done), .err_clr(err_clr),
    .ecc_err_sticky(s_ecc), .pop_cnt(s_pop_cnt), .drop_cnt(s_drop_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: FIFO contents, entries accepted but not yet delivered, and stats.
  ent_t          fifo_q[$];
  logic [DW-1:0] m_pend[$];
  bit            m_drain = 1'b0;
  bit            m_done  = 1'b0;
  bit            m_ecc   = 1'b0;
  int            m_pop   = 0;
  int            m_pop4  = 0;
  int            m_drop  = 0;
  int            done_seen = 0;

  function automatic logic [DW-1:0] rand_data();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  function automatic ent_t mk(input logic ecc);
    ent_t e;
    e.ecc  = ecc;
    e.data = rand_data();
    return e;
  endfunction

  task automatic tick();
    ent_t e, dummy;
    logic exp_ren, exp_vld;
    fifo_empty   = (fifo_q.size() == 0);
    e            = fifo_empty ? '0 : fifo_q[0];
    fifo_rdata   = e.data;
    fifo_ecc_err = e.ecc;
    @(negedge clk);
    exp_vld = (m_pend.size() != 0);
    exp_ren = !rst && !fifo_empty && (m_drain || m_pend.size() < 2);
    total++;
    if (fifo_ren !== exp_ren) $display("FAIL fifo_ren: got %b want %b at %0t", fifo_ren, exp_ren, $time);
    else passed++;
    total++;
    if (out_valid !== exp_vld) $display("FAIL out_valid: got %b want %b at %0t", out_valid, exp_vld, $time);
    else passed++;
    if (exp_vld) begin
      total++;
      if (out_data !== m_pend[0]) $display("FAIL out_data: got %h want %h at %0t", out_data, m_pend[0], $time);
      else passed++;
    end
    if (rst) begin
      m_pend.delete();
      m_drain = 0; m_done = 0; m_ecc = 0; m_pop = 0; m_pop4 = 0; m_drop = 0;
    end else begin
      if (!m_drain) begin
        if (exp_vld && out_ready) begin
          void'(m_pend.pop_front());
          if (m_pop < 65535) m_pop++;
          if (m_pop4 < 15) m_pop4++;
        end
        if (exp_ren) m_pend.push_back(e.data);
        if (drain_req) begin
          m_drop = m_drop + m_pend.size();
          if (m_drop > 65535) m_drop = 65535;
          m_pend.delete();
          m_drain = 1;
        end
        m_done = 0;
      end else begin
        if (exp_ren && m_drop < 65535) m_drop++;
        m_done = fifo_empty;
        if (fifo_empty) m_drain = 0;
      end
      if (exp_ren && e.ecc) m_ecc = 1;
      else if (err_clr)     m_ecc = 0;
    end
    if (fifo_ren === 1'b1 && fifo_q.size() != 0) dummy = fifo_q.pop_front();
    @(posedge clk);
    #1;
    total++;
    if (pop_cnt !== 16'(m_pop)) $display("FAIL pop_cnt: got %0d want %0d", pop_cnt, m_pop);
    else passed++;
    total++;
    if (drop_cnt !== 16'(m_drop)) $display("FAIL drop_cnt: got %0d want %0d", drop_cnt, m_drop);
    else passed++;
    total++;
    if (ecc_err_sticky !== m_ecc) $display("FAIL ecc_err_sticky: got %b want %b", ecc_err_sticky, m_ecc);
    else passed++;
    total++;
    if (drain_busy !== m_drain) $display("FAIL drain_busy: got %b want %b", drain_busy, m_drain);
    else passed++;
    total++;
    if (drain_done !== m_done) $display("FAIL drain_done: got %b want %b", drain_done, m_done);
    else passed++;
    total++;
    if (s_pop_cnt !== 4'(m_pop4)) $display("FAIL sat_pop_cnt: got %0d want %0d", s_pop_cnt, m_pop4);
    else passed++;
    if (drain_done === 1'b1) done_seen++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ticks(2);
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || drain_busy !== 1'b0 || drain_done !== 1'b0 ||
        ecc_err_sticky !== 1'b0 || pop_cnt !== 16'd0 || drop_cnt !== 16'd0)
      $display("FAIL reset_values: vld=%b data=%h busy=%b done=%b ecc=%b pop=%0d drop=%0d want all zero",
               out_valid, out_data, drain_busy, drain_done, ecc_err_sticky, pop_cnt, drop_cnt);
    else passed++;
  endtask

  task automatic test_basic();
    ent_t a;
    a = mk(1'b0);
    fifo_q.push_back(a);
    fifo_q.push_back(mk(1'b0));
    fifo_q.push_back(mk(1'b0));
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== a.data)
      $display("FAIL first_latency: vld=%b data=%h want vld=1 data=%h", out_valid, out_data, a.data);
    else passed++;
    ticks(4);
    total++;
    if (pop_cnt !== 16'd3 || out_valid !== 1'b0)
      $display("FAIL basic_pop_cnt: pop=%0d vld=%b want pop=3 vld=0", pop_cnt, out_valid);
    else passed++;
  endtask

  task automatic test_backpressure();
    ent_t a;
    int p0;
    p0 = m_pop;
    out_ready = 1'b0;
    a = mk(1'b0);
    fifo_q.push_back(a);
    for (int i = 0; i < 3; i++) fifo_q.push_back(mk(1'b0));
    ticks(5);
    total++;
    if (out_data !== a.data || fifo_q.size() != 2 || fifo_ren !== 1'b0)
      $display("FAIL backpressure_hold: data=%h left=%0d ren=%b want data=%h left=2 ren=0",
               out_data, fifo_q.size(), fifo_ren, a.data);
    else passed++;
    out_ready = 1'b1;
    ticks(6);
    total++;
    if (pop_cnt !== 16'(p0 + 4) || out_valid !== 1'b0)
      $display("FAIL backpressure_release: pop=%0d vld=%b want pop=%0d vld=0", pop_cnt, out_valid, p0 + 4);
    else passed++;
  endtask

  task automatic test_drain();
    int d0, p0, ds, i;
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) fifo_q.push_back(mk(1'b0));
    ticks(3);
    total++;
    if (fifo_q.size() != 5) $display("FAIL drain_setup: fifo left %0d want 5", fifo_q.size());
    else passed++;
    d0 = m_drop;
    ds = done_seen;
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    total++;
    if (drain_busy !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL drain_entry: busy=%b vld=%b want busy=1 vld=0", drain_busy, out_valid);
    else passed++;
    for (i = 0; i < 20; i++) begin
      tick();
      if (drain_done === 1'b1) break;
    end
    total++;
    if (i == 20) $display("FAIL drain_timeout: no drain_done within 20 cycles");
    else passed++;
    total++;
    if (drop_cnt !== 16'(d0 + 7) || fifo_q.size() != 0 || drain_busy !== 1'b0)
      $display("FAIL drain_result: drop=%0d left=%0d busy=%b want drop=%0d left=0 busy=0",
               drop_cnt, fifo_q.size(), drain_busy, d0 + 7);
    else passed++;
    tick();
    total++;
    if (drain_done !== 1'b0 || done_seen != ds + 1)
      $display("FAIL drain_pulse: done=%b pulses=%0d want done=0 pulses=1", drain_done, done_seen - ds);
    else passed++;
    p0 = m_pop;
    fifo_q.push_back(mk(1'b0));
    out_ready = 1'b1;
    ticks(3);
    total++;
    if (pop_cnt !== 16'(p0 + 1)) $display("FAIL post_drain_delivery: pop=%0d want %0d", pop_cnt, p0 + 1);
    else passed++;
  endtask

  task automatic test_ecc();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    out_ready = 1'b1;
    fifo_q.push_back(mk(1'b0));
    fifo_q.push_back(mk(1'b1));
    fifo_q.push_back(mk(1'b0));
    tick();
    total++;
    if (ecc_err_sticky !== 1'b0) $display("FAIL ecc_early: got %b want 0", ecc_err_sticky);
    else passed++;
    ticks(4);
    total++;
    if (ecc_err_sticky !== 1'b1) $display("FAIL ecc_set: got %b want 1", ecc_err_sticky);
    else passed++;
    fifo_q.push_back(mk(1'b1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if (ecc_err_sticky !== 1'b1) $display("FAIL ecc_set_wins: got %b want 1", ecc_err_sticky);
    else passed++;
    ticks(2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if (ecc_err_sticky !== 1'b0) $display("FAIL ecc_clear: got %b want 0", ecc_err_sticky);
    else passed++;
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) fifo_q.push_back(mk(1'b0));
    ticks(25);
    total++;
    if (s_pop_cnt !== 4'd15 || pop_cnt !== 16'd20)
      $display("FAIL saturation: sat_pop=%0d pop=%0d want 15 and 20", s_pop_cnt, pop_cnt);
    else passed++;
  endtask

  task automatic test_mid_drain_reset();
    int ds;
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) fifo_q.push_back(mk(1'b0));
    ticks(3);
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    tick();
    total++;
    if (drain_busy !== 1'b1) $display("FAIL mid_drain_busy: got %b want 1", drain_busy);
    else passed++;
    ds = done_seen;
    rst = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || drain_busy !== 1'b0 || drain_done !== 1'b0 ||
        ecc_err_sticky !== 1'b0 || pop_cnt !== 16'd0 || drop_cnt !== 16'd0)
      $display("FAIL mid_drain_reset: vld=%b busy=%b done=%b pop=%0d drop=%0d want all zero",
               out_valid, drain_busy, drain_done, pop_cnt, drop_cnt);
    else passed++;
    rst = 1'b0;
    out_ready = 1'b1;
    ticks(8);
    total++;
    if (done_seen != ds) $display("FAIL mid_drain_no_done: pulses=%0d want 0", done_seen - ds);
    else passed++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(3) != 0);
      drain_req = ($urandom_range(39) == 0);
      err_clr   = ($urandom_range(19) == 0);
      if (fifo_q.size() < 6 && $urandom_range(1) == 1) fifo_q.push_back(mk($urandom_range(9) == 0));
      tick();
    end
    drain_req = 1'b0;
    err_clr   = 1'b0;
    out_ready = 1'b1;
    ticks(12);
    total++;
    if (out_valid !== 1'b0 || fifo_q.size() != 0 || drain_busy !== 1'b0)
      $display("FAIL random_flush: vld=%b left=%0d busy=%b want 0/0/0", out_valid, fifo_q.size(), drain_busy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_drain();
    test_ecc();
    test_saturation();
    test_mid_drain_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
